// File: rtl/core_local_timer.sv
// Memory-mapped machine timer and software-interrupt unit on the drisc data bus.
// Holds mtime/mtimecmp/msip, a prescaler and a high-word snapshot for torn-free 64-bit reads.
module core_local_timer #(
    parameter logic [31:0] BASE_ADDRESS = 32'hFFFF_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_bus,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_size,
    input  logic        write,
    input  logic        read,
    output logic [31:0] data_out,
    output logic        selected,
    output logic        timer_interrupt,
    output logic        software_interrupt
);

    localparam logic [5:0] OFF_MSIP      = 6'h00;
    localparam logic [5:0] OFF_CTRL      = 6'h04;
    localparam logic [5:0] OFF_PRESCALE  = 6'h08;
    localparam logic [5:0] OFF_MTIME_LO  = 6'h10;
    localparam logic [5:0] OFF_MTIME_HI  = 6'h14;
    localparam logic [5:0] OFF_CMP_LO    = 6'h18;
    localparam logic [5:0] OFF_CMP_HI    = 6'h1C;
    localparam logic [5:0] OFF_SNAP      = 6'h20;

    logic        msip_r;
    logic        enable_r;
    logic [15:0] prescale_r;
    logic [15:0] pcount_r;
    logic [63:0] mtime_r;
    logic [63:0] mtimecmp_r;
    logic [31:0] snap_r;
    logic        timer_irq_r;

    logic        sel_s;
    logic        valid_s;
    logic        wr_s;
    logic        rd_s;
    logic [5:0]  offset_s;
    logic        tick_s;
    logic [31:0] rdata_s;

    // Only aligned word accesses inside the window reach the registers
    assign sel_s    = (address_bus[31:6] == BASE_ADDRESS[31:6]);
    assign offset_s = address_bus[5:0];
    assign valid_s  = sel_s && (data_size == 2'd2) && (address_bus[1:0] == 2'b00);
    assign wr_s     = valid_s && write;
    assign rd_s     = valid_s && read;
    assign tick_s   = enable_r && (pcount_r == prescale_r);

    assign selected           = sel_s;
    assign data_out           = rdata_s;
    assign timer_interrupt    = timer_irq_r;
    assign software_interrupt = msip_r;

    // Read mux: zero when not addressed so the system bus can OR sources together
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (rd_s) begin
            case (offset_s)
                OFF_MSIP:     rdata_s = {31'h0000_0000, msip_r};
                OFF_CTRL:     rdata_s = {31'h0000_0000, enable_r};
                OFF_PRESCALE: rdata_s = {16'h0000, prescale_r};
                OFF_MTIME_LO: rdata_s = mtime_r[31:0];
                OFF_MTIME_HI: rdata_s = mtime_r[63:32];
                OFF_CMP_LO:   rdata_s = mtimecmp_r[31:0];
                OFF_CMP_HI:   rdata_s = mtimecmp_r[63:32];
                OFF_SNAP:     rdata_s = snap_r;
                default:      rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // Software-writable control registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            msip_r     <= 1'b0;
            enable_r   <= 1'b1;
            prescale_r <= 16'h0000;
            mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (wr_s) begin
            case (offset_s)
                OFF_MSIP:     msip_r             <= data_in[0];
                OFF_CTRL:     enable_r           <= data_in[0];
                OFF_PRESCALE: prescale_r         <= data_in[15:0];
                OFF_CMP_LO:   mtimecmp_r[31:0]   <= data_in;
                OFF_CMP_HI:   mtimecmp_r[63:32]  <= data_in;
                default:      ;
            endcase
        end
    end

    // Prescaler and mtime; a half-word write beats a coincident tick without carry
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pcount_r <= 16'h0000;
            mtime_r  <= 64'h0000_0000_0000_0000;
        end else begin
            if (wr_s && (offset_s == OFF_PRESCALE)) begin
                pcount_r <= 16'h0000;
            end else if (enable_r) begin
                pcount_r <= tick_s ? 16'h0000 : pcount_r + 16'd1;
            end
            if (wr_s && (offset_s == OFF_MTIME_LO)) begin
                mtime_r[31:0] <= data_in;
            end else if (wr_s && (offset_s == OFF_MTIME_HI)) begin
                mtime_r[63:32] <= data_in;
            end else if (tick_s) begin
                mtime_r <= mtime_r + 64'd1;
            end
        end
    end

    // High-word snapshot taken whenever the low word is read, plus the compare
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap_r      <= 32'h0000_0000;
            timer_irq_r <= 1'b0;
        end else begin
            if (rd_s && (offset_s == OFF_MTIME_LO)) begin
                snap_r <= mtime_r[63:32];
            end
            timer_irq_r <= (mtime_r >= mtimecmp_r);
        end
    end

endmodule
